// File: rtl/uart_transmitter.sv
// Drains 32-bit words from a standard FIFO and sends each one as FIFO_RD_BYTE 8N1 frames.
// Bytes go out most-significant first, and each byte is sent LSB first.
module uart_transmitter #(
  parameter int UART_BPS      = 'd9600,
  parameter int CLK_FREQ      = 'd50_000_000,
  parameter int FIFO_RD_WIDTH = 'd32,
  parameter int FIFO_RD_BYTE  = 'd4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
  output logic                     fifo_rd_en,
  output logic                     tx,
  output logic                     busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int BAUD_W       = $clog2(BAUD_CNT_MAX);
  localparam int BYTE_W       = (FIFO_RD_BYTE > 1) ? $clog2(FIFO_RD_BYTE) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FIFO_RD_BYTE - 1);

  typedef enum logic [1:0] {IDLE, RD, LOAD, SEND} state_t;

  state_t                   state, next_state;
  logic [FIFO_RD_WIDTH-1:0] word_reg;
  logic [BAUD_W-1:0]        baud_cnt;
  logic [3:0]               bit_idx;
  logic [BYTE_W-1:0]        byte_idx;
  logic [7:0]               sel_byte;
  logic                     baud_wrap, bit_last, byte_last;
  logic                     tx_d, rd_en_d;

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign bit_last  = (bit_idx == 4'd9);
  assign byte_last = (byte_idx == BYTE_LAST);
  assign sel_byte  = 8'(word_reg >> (8 * (FIFO_RD_BYTE - 1 - int'(byte_idx))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty) next_state = RD;
      RD:      next_state = LOAD;
      LOAD:    next_state = SEND;
      SEND:    if (baud_wrap && bit_last && byte_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // tx_d is the line level for the bit that begins on the coming edge.
  always_comb begin
    tx_d    = tx;
    rd_en_d = 1'b0;
    case (state)
      IDLE: begin
        tx_d    = 1'b1;
        rd_en_d = !fifo_empty;
      end
      LOAD: tx_d = 1'b0;
      SEND: begin
        if (baud_wrap) begin
          if (bit_last)            tx_d = byte_last;
          else if (bit_idx == 4'd8) tx_d = 1'b1;
          else                     tx_d = sel_byte[bit_idx[2:0]];
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tx         <= tx_d;
      fifo_rd_en <= rd_en_d;
      busy       <= (next_state != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_reg <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      case (state)
        LOAD: begin
          word_reg <= fifo_rd_data;
          baud_cnt <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
        end
        SEND: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_last) begin
              bit_idx <= '0;
              if (!byte_last) byte_idx <= byte_idx + 1'b1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter, run with a shortened bit period (16 clocks).
// tx is decoded from a per-cycle line history that is sampled on the falling clock edge.
module tb_uart_transmitter;
  localparam int B        = 16;
  localparam int NB       = 4;
  localparam int WORD_CYC = 10 * NB * B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_en, tx, busy;

  int          n_checks = 0;
  int          n_pass = 0;
  logic        tx_hist[$];
  logic        busy_hist[$];
  int          strobe_q[$];
  logic [31:0] fifo_q[$];

  uart_transmitter #(
    .UART_BPS(100), .CLK_FREQ(1600), .FIFO_RD_WIDTH(32), .FIFO_RD_BYTE(4)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  // One falling edge: log the outputs and let the FIFO model service a strobe.
  task automatic tick();
    @(negedge clk);
    if (fifo_rd_en) begin
      strobe_q.push_back(tx_hist.size());
      if (fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
      else                   fifo_rd_data = $urandom;
      fifo_empty = (fifo_q.size() == 0);
    end
    tx_hist.push_back(tx);
    busy_hist.push_back(busy);
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_for(input int n, input bit need_idle, input int budget, input string name);
    int c;
    c = 0;
    while (!(strobe_q.size() >= n && (!need_idle || !busy)) && c < budget) begin
      tick();
      c++;
    end
    if (c >= budget) begin
      n_checks++;
      $display("FAIL %s timeout: strobes=%0d busy=%b, required strobes=%0d", name, strobe_q.size(), busy, n);
    end
  endtask

  // Sample the centre of each bit slot of a word whose strobe was at history index s.
  task automatic decode(input int s, output logic [31:0] w, output int ferr);
    int   i;
    logic v;
    w = '0;
    ferr = 0;
    for (int k = 0; k < NB; k++) begin
      for (int j = 0; j < 10; j++) begin
        i = s + 2 + (10 * k + j) * B + B / 2;
        v = (i < tx_hist.size()) ? tx_hist[i] : 1'bx;
        if (j == 0) begin
          if (v !== 1'b0) ferr++;
        end else if (j == 9) begin
          if (v !== 1'b1) ferr++;
        end else begin
          w[8 * (NB - 1 - k) + j - 1] = v;
        end
      end
    end
  endtask

  task automatic test_reset();
    int rel, first;
    rst = 1'b1;
    push(32'hA53C0F81);
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if ({tx, fifo_rd_en, busy} !== 3'b100)
        $display("FAIL reset_hold: tx/rd_en/busy=%b required 100", {tx, fifo_rd_en, busy});
      else n_pass++;
    end
    rel = tx_hist.size();
    rst = 1'b0;
    tick();
    first = (strobe_q.size() > 0) ? strobe_q[0] : -1;
    n_checks++;
    if (first !== rel) $display("FAIL reset_first_strobe: at %0d required %0d", first, rel);
    else n_pass++;
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    int ferr, s, e;
    wait_for(1, 1'b1, 2 * WORD_CYC, "single_done");
    for (int c = 0; c < 2 * B; c++) tick();
    s = strobe_q[0];
    e = s + 2 + WORD_CYC;
    decode(s, w, ferr);
    n_checks++;
    if (strobe_q.size() !== 1) $display("FAIL single_strobes: %0d required 1", strobe_q.size());
    else n_pass++;
    n_checks++;
    if (busy_hist[s] !== 1'b1) $display("FAIL single_busy_e0: %b required 1", busy_hist[s]);
    else n_pass++;
    n_checks++;
    if ({tx_hist[s + 1], tx_hist[s + 2]} !== 2'b10)
      $display("FAIL single_start_edge: %b required 10", {tx_hist[s + 1], tx_hist[s + 2]});
    else n_pass++;
    n_checks++;
    if (w !== 32'hA53C0F81) $display("FAIL single_data: %h required a53c0f81", w);
    else n_pass++;
    n_checks++;
    if (ferr !== 0) $display("FAIL single_framing: %0d errors required 0", ferr);
    else n_pass++;
    n_checks++;
    if ({busy_hist[e - 1], busy_hist[e], tx_hist[e]} !== 3'b101)
      $display("FAIL single_end: busy_before/busy/tx=%b required 101",
               {busy_hist[e - 1], busy_hist[e], tx_hist[e]});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    int ferr, base;
    base = strobe_q.size();
    push(32'h01234567);
    push(32'h89ABCDEF);
    wait_for(base + 2, 1'b1, 3 * WORD_CYC, "b2b_done");
    for (int c = 0; c < 2 * B; c++) tick();
    n_checks++;
    if (strobe_q.size() !== base + 2) $display("FAIL b2b_strobes: %0d required %0d", strobe_q.size(), base + 2);
    else n_pass++;
    if (strobe_q.size() >= base + 2) begin
      n_checks++;
      if (strobe_q[base + 1] - strobe_q[base] !== WORD_CYC + 3)
        $display("FAIL b2b_spacing: %0d required %0d", strobe_q[base + 1] - strobe_q[base], WORD_CYC + 3);
      else n_pass++;
      decode(strobe_q[base], w, ferr);
      n_checks++;
      if (w !== 32'h01234567 || ferr !== 0) $display("FAIL b2b_word0: %h/%0d required 01234567/0", w, ferr);
      else n_pass++;
      decode(strobe_q[base + 1], w, ferr);
      n_checks++;
      if (w !== 32'h89ABCDEF || ferr !== 0) $display("FAIL b2b_word1: %h/%0d required 89abcdef/0", w, ferr);
      else n_pass++;
    end
  endtask

  task automatic test_idle_empty();
    int base, bad, s, ferr;
    logic [31:0] w, got;
    base = strobe_q.size();
    fifo_empty = 1'b1;
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if ({tx, fifo_rd_en, busy} !== 3'b100) bad++;
    end
    n_checks++;
    if (bad !== 0 || strobe_q.size() !== base)
      $display("FAIL idle_empty: bad_cycles=%0d strobes=%0d required 0/%0d", bad, strobe_q.size(), base);
    else n_pass++;
    w = $urandom;
    push(w);
    wait_for(base + 1, 1'b0, 4 * B, "toggle_strobe");
    s = (strobe_q.size() > base) ? strobe_q[base] : tx_hist.size();
    while (tx_hist.size() < s + 2 + WORD_CYC - 4 * B) begin
      tick();
      fifo_empty = 1'($urandom_range(0, 1));
    end
    fifo_empty = 1'b1;
    wait_for(base + 1, 1'b1, 2 * WORD_CYC, "toggle_done");
    for (int c = 0; c < 2 * B; c++) tick();
    n_checks++;
    if (strobe_q.size() !== base + 1) $display("FAIL toggle_strobes: %0d required %0d", strobe_q.size(), base + 1);
    else n_pass++;
    decode(s, got, ferr);
    n_checks++;
    if (got !== w || ferr !== 0) $display("FAIL toggle_data: %h/%0d required %h/0", got, ferr, w);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base, s, bad;
    base = strobe_q.size();
    push(32'hFFFF00FF);
    wait_for(base + 1, 1'b0, 4 * B, "rmid_strobe");
    s = (strobe_q.size() > base) ? strobe_q[base] : tx_hist.size();
    while (tx_hist.size() < s + 2 + 24 * B) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({tx, fifo_rd_en, busy} !== 3'b100)
      $display("FAIL rmid_async: tx/rd_en/busy=%b required 100", {tx, fifo_rd_en, busy});
    else n_pass++;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 50 * B; c++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0 || strobe_q.size() !== base + 1)
      $display("FAIL rmid_after: bad_cycles=%0d strobes=%0d required 0/%0d", bad, strobe_q.size(), base + 1);
    else n_pass++;
    push($urandom);
    wait_for(base + 2, 1'b0, 4 * B, "rcut_strobe");
    rst = 1'b1;
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b0) $display("FAIL rcut_strobe_cut: rd_en=%b required 0", fifo_rd_en);
    else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 50 * B; c++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    n_checks++;
    if (bad !== 0 || strobe_q.size() !== base + 2)
      $display("FAIL rcut_no_reread: bad_cycles=%0d strobes=%0d required 0/%0d", bad, strobe_q.size(), base + 2);
    else n_pass++;
  endtask

  task automatic test_bit_period();
    int base, s, prev, n_edges, bad, exp_edges;
    logic seq[$];
    logic [31:0] w;
    w = 32'h55555555;
    seq.push_back(1'b1);
    for (int k = 0; k < NB; k++) begin
      seq.push_back(1'b0);
      for (int j = 0; j < 8; j++) seq.push_back(w[8 * (NB - 1 - k) + j]);
      seq.push_back(1'b1);
    end
    seq.push_back(1'b1);
    exp_edges = 0;
    for (int i = 1; i < seq.size(); i++) if (seq[i] != seq[i - 1]) exp_edges++;
    base = strobe_q.size();
    push(w);
    wait_for(base + 1, 1'b1, 2 * WORD_CYC, "bitp_done");
    for (int c = 0; c < 2 * B; c++) tick();
    s = (strobe_q.size() > base) ? strobe_q[base] : 0;
    prev = s + 2;
    n_edges = 0;
    bad = 0;
    for (int i = s + 1; i < tx_hist.size(); i++) begin
      if (tx_hist[i] !== tx_hist[i - 1]) begin
        if (n_edges == 0 && i != s + 2) bad++;
        if ((i - prev) % B != 0) bad++;
        prev = i;
        n_edges++;
      end
    end
    n_checks++;
    if (n_edges !== exp_edges) $display("FAIL bitp_edges: %0d required %0d", n_edges, exp_edges);
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL bitp_intervals: %0d bad required 0", bad);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] words[3];
    logic [31:0] got;
    int base, ferr;
    base = strobe_q.size();
    for (int i = 0; i < 3; i++) begin
      words[i] = $urandom;
      push(words[i]);
    end
    wait_for(base + 3, 1'b1, 4 * WORD_CYC, "rand_done");
    for (int c = 0; c < 2 * B; c++) tick();
    if (strobe_q.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) begin
        decode(strobe_q[base + i], got, ferr);
        n_checks++;
        if (got !== words[i] || ferr !== 0)
          $display("FAIL rand_word%0d: %h/%0d required %h/0", i, got, ferr, words[i]);
        else n_pass++;
        if (i > 0) begin
          n_checks++;
          if (strobe_q[base + i] - strobe_q[base + i - 1] !== WORD_CYC + 3)
            $display("FAIL rand_spacing%0d: %0d required %0d", i,
                     strobe_q[base + i] - strobe_q[base + i - 1], WORD_CYC + 3);
          else n_pass++;
        end
      end
    end else begin
      n_checks++;
      $display("FAIL rand_strobes: %0d required %0d", strobe_q.size(), base + 3);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_idle_empty();
    test_reset_mid();
    test_bit_period();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial-output counterpart of the 32-bit UART receive path: pops 32-bit words from a standard (non-first-word-fall-through) FIFO and shifts each out on `tx` as FIFO_RD_BYTE 8N1 UART frames, most-significant byte first, LSB-first within each byte. It sits between the readback FIFO (DDR3 read data) and the board UART pin, giving byte order and framing identical to what the PC-side sender uses toward the receiver.

## Interface
- `UART_BPS`, 'd9600, serial baud rate
- `CLK_FREQ`, 'd50_000_000, `clk` frequency in Hz
- `FIFO_RD_WIDTH`, 'd32, FIFO read-port data width; must equal 8*FIFO_RD_BYTE
- `FIFO_RD_BYTE`, 'd4, bytes per FIFO word
- Derived localparam BAUD_CNT_MAX = CLK_FREQ/UART_BPS (5208 at defaults); baud counter width = $clog2(BAUD_CNT_MAX)

- `clk`  input  1  system clock, same clock as FIFO read port
- `rst`  input  1  reset, asynchronous, active-high
- `fifo_empty`  input  1  FIFO empty flag
- `fifo_rd_data`  input  FIFO_RD_WIDTH  FIFO read data, valid the cycle after a read strobe
- `fifo_rd_en`  output  1  FIFO read strobe, single-cycle pulse per word
- `tx`  output  1  UART serial output, idle high
- `busy`  output  1  high while a word is being fetched or sent

## Operation
- States: IDLE, RD, LOAD, SEND.
- IDLE: `tx`=1. On an edge where `fifo_empty`=0: `fifo_rd_en`<=1, go RD. `fifo_empty`=1: stay.
- RD: `fifo_rd_en`<=0, go LOAD (FIFO presents data during this cycle).
- LOAD: capture `fifo_rd_data` into word register; byte_idx<=0, bit_idx<=0, baud_cnt<=0, `tx`<=0 (start bit of byte 0); go SEND.
- SEND: baud_cnt counts 0..BAUD_CNT_MAX-1 then wraps to 0; on wrap bit_idx advances 0..9. Per-byte bit sequence: bit_idx 0 start (0), 1..8 data[0]..data[7], 9 stop (1).
- Byte selection: byte_idx 0 = word[31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0] (general: byte k = word[8*(FIFO_RD_BYTE-k)-1 -: 8]).
- On wrap at bit_idx 9: if byte_idx < FIFO_RD_BYTE-1, byte_idx++, bit_idx<=0, `tx`<=0 immediately (no inter-byte gap); else go IDLE, `tx` stays 1.
- `fifo_empty` and `fifo_rd_data` ignored outside IDLE and LOAD respectively; at most one word in flight.
- `busy` = (state != IDLE), registered.
- All outputs registered; `tx` never glitches.

## Timing
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, state IDLE, all counters 0, word register 0.
- Edge E0 (IDLE, `fifo_empty`=0): `fifo_rd_en`=1 from E0 to E1; `busy`=1 from E0.
- Edge E2: data captured, `tx` falls.
- Every bit lasts exactly BAUD_CNT_MAX cycles (5208); byte = 10*5208 = 52080 cycles; word = 208320 cycles from E2.
- Last stop bit ends at E2+208320: state IDLE, `busy`=0. If `fifo_empty`=0 then, next edge is the next E0 → idle-high gap between words = 1 stop-bit-extension of 3 cycles (E_end to next E2).
- Reset asserted mid-operation: all outputs to reset values asynchronously; in-flight word discarded (not re-read); a `fifo_rd_en` in progress is cut short. After release, resume from IDLE.
- `fifo_empty` rising during RD has no effect (read already issued).

## Test plan
- Reset: hold `rst`=1 with `fifo_empty`=0 → `tx`=1, `fifo_rd_en`=0, `busy`=0 throughout; first `fifo_rd_en` on first edge after release.
- Single word 32'hA53C0F81 → exactly one 1-cycle `fifo_rd_en`; `tx` decodes (sampling at bit centres, 5208-cycle bits) to bytes A5, 3C, 0F, 81 in order, each with start 0 and stop 1; start edge 2 cycles after strobe.
- Back-to-back words 32'h01234567, 32'h89ABCDEF with `fifo_empty`=0 → two strobes 208323 cycles apart; 8 bytes 01 23 45 67 89 AB CD EF; no inter-byte gap inside a word.
- `fifo_empty`=1 for 100000 cycles → no strobe, `tx`=1, `busy`=0; toggling `fifo_empty` during SEND causes no extra strobe.
- Reset pulse mid byte 2 of 32'hFFFF00FF → `tx`=1 within the reset, `busy`=0; after release with `fifo_empty`=1 nothing further sent.
- Bit-period check: measure every `tx` edge over word 32'h55555555 → all intervals exact multiples of 5208 cycles.
